// File: rtl/pc_ras.sv
// ============================================================================
// Module      : pc_ras
// Description : Fetch-stage program counter with stall, exception redirect,
//               exception return and a circular return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [1:0]                   pc_inc_type,
    input  logic                         alu_branch_result,
    input  logic                         link,
    input  logic [ADDR_WIDTH-1:0]        abs_addr,
    input  logic [ADDR_WIDTH-1:0]        branch_addr,
    input  logic                         exception,
    input  logic                         eret,
    output logic [ADDR_WIDTH-1:0]        current_pc,
    output logic [ADDR_WIDTH-1:0]        epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_hit
);

    localparam int                 c_PTR_W = $clog2(RAS_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(RAS_DEPTH);

    localparam logic [1:0] c_TYPE_SEQ = 2'b00;
    localparam logic [1:0] c_TYPE_BR  = 2'b01;
    localparam logic [1:0] c_TYPE_JMP = 2'b10;
    localparam logic [1:0] c_TYPE_RET = 2'b11;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_ptr;
    logic                  r_hit;
    logic [ADDR_WIDTH-1:0] r_stack [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0] w_seq;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [c_PTR_W-1:0]    w_top_idx;
    logic                  w_advance;
    logic                  w_taken;
    logic                  w_push;
    logic                  w_pop;

    assign w_seq     = r_pc + ADDR_WIDTH'(4);
    assign w_advance = !exception && !eret && !stall;
    assign w_taken   = (pc_inc_type == c_TYPE_JMP) ||
                       ((pc_inc_type == c_TYPE_BR) && alu_branch_result);
    assign w_push    = w_advance && link && w_taken;
    assign w_pop     = w_advance && (pc_inc_type == c_TYPE_RET) && (r_count != '0);
    // r_ptr names the next free slot, so the top of stack sits one below it
    assign w_top_idx = r_ptr - c_PTR_W'(1);

    always_comb begin
        w_next_pc = w_seq;
        case (pc_inc_type)
            c_TYPE_SEQ: w_next_pc = w_seq;
            c_TYPE_BR:  w_next_pc = alu_branch_result ? branch_addr : w_seq;
            c_TYPE_JMP: w_next_pc = abs_addr;
            c_TYPE_RET: w_next_pc = (r_count != '0) ? r_stack[w_top_idx] : abs_addr;
            default:    w_next_pc = w_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_count <= '0;
            r_ptr   <= '0;
            r_hit   <= 1'b0;
        end else if (exception) begin
            r_epc <= r_pc;
            r_pc  <= EXC_VECTOR;
            r_hit <= 1'b0;
        end else if (eret) begin
            r_pc  <= r_epc;
            r_hit <= 1'b0;
        end else if (!stall) begin
            r_pc  <= w_next_pc;
            r_hit <= w_pop;
            if (w_push) begin
                // When full the pointer wraps onto the oldest entry
                r_ptr <= r_ptr + c_PTR_W'(1);
                if (r_count != c_FULL) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_ptr] <= w_seq;
        end
    end

    assign current_pc = r_pc;
    assign epc        = r_epc;
    assign ras_count  = r_count;
    assign ras_hit    = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_pc_ras.sv
// ============================================================================
// Module      : tb_pc_ras
// Description : Scoreboard bench for pc_ras against a queue-based RAS model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ras;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_RV    = 32'h0000_0000;
    localparam logic [31:0] c_EV    = 32'h0000_0180;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        int          cnt;
        logic        hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_inc_type = 2'b00;
    logic        alu_branch_result = 1'b0;
    logic        link = 1'b0;
    logic [31:0] abs_addr = '0;
    logic [31:0] branch_addr = '0;
    logic        exception = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] current_pc;
    logic [31:0] epc;
    logic [2:0]  ras_count;
    logic        ras_hit;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] ras[$];
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_hit;

    pc_ras #(
        .ADDR_WIDTH  (32),
        .RESET_VECTOR(c_RV),
        .EXC_VECTOR  (c_EV),
        .RAS_DEPTH   (c_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc_inc_type      (pc_inc_type),
        .alu_branch_result(alu_branch_result),
        .link             (link),
        .abs_addr         (abs_addr),
        .branch_addr      (branch_addr),
        .exception        (exception),
        .eret             (eret),
        .current_pc       (current_pc),
        .epc              (epc),
        .ras_count        (ras_count),
        .ras_hit          (ras_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the RAS is a plain list; calls append, returns take the newest,
    // overflow discards the oldest.
    task automatic model(input logic r, e, er, s, input logic [1:0] t,
                         input logic br, lk, input logic [31:0] ab, bra);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (r) begin
            m_pc = c_RV; m_epc = '0; m_hit = 1'b0; ras.delete();
        end else if (e) begin
            m_epc = m_pc; m_pc = c_EV; m_hit = 1'b0;
        end else if (er) begin
            m_pc = m_epc; m_hit = 1'b0;
        end else if (!s) begin
            m_hit = 1'b0;
            if (t == 2'd0) m_pc = seq;
            else if (t == 2'd1) m_pc = br ? bra : seq;
            else if (t == 2'd2) m_pc = ab;
            else if (ras.size() > 0) begin
                m_pc = ras.pop_back(); m_hit = 1'b1;
            end else m_pc = ab;
            if (lk && (t == 2'd2 || (t == 2'd1 && br))) begin
                ras.push_back(seq);
                if (ras.size() > c_DEPTH) void'(ras.pop_front());
            end
        end
    endtask

    task automatic drive(input logic r, e, er, s, input logic [1:0] t,
                         input logic br, lk, input logic [31:0] ab, bra);
        exp_t x;
        @(negedge clk);
        rst = r; exception = e; eret = er; stall = s; pc_inc_type = t;
        alu_branch_result = br; link = lk; abs_addr = ab; branch_addr = bra;
        model(r, e, er, s, t, br, lk, ab, bra);
        x.pc = m_pc; x.epc = m_epc; x.cnt = ras.size(); x.hit = m_hit;
        exp_q.push_back(x);
    endtask

    task automatic op(input logic [1:0] t, input logic br, lk, input logic [31:0] ab, bra);
        drive(1'b0, 1'b0, 1'b0, 1'b0, t, br, lk, ab, bra);
    endtask

    task automatic jump_to(input logic [31:0] a);
        op(2'd2, 1'b0, 1'b0, a, 32'h0);
    endtask

    // Monitor: every edge with an outstanding request is compared after settling
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("current_pc", current_pc, e.pc);
                check("epc", epc, e.epc);
                check("ras_count", {29'd0, ras_count}, e.cnt);
                check("ras_hit", {31'd0, ras_hit}, {31'd0, e.hit});
            end
        end
    end

    initial begin
        m_pc = '0; m_epc = '0; m_hit = 1'b0;

        // Reset and sequential stepping, then stall hold
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) op(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 32'h77, 32'h0);

        // Branches, jumps, wraparound
        jump_to(32'h100);
        op(2'd1, 1'b0, 1'b1, 32'h0, 32'h400);
        op(2'd1, 1'b1, 1'b0, 32'h0, 32'h400);
        op(2'd2, 1'b0, 1'b0, 32'h2000, 32'h0);
        jump_to(32'hFFFF_FFFC);
        op(2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        // Call / return
        jump_to(32'h1000);
        op(2'd2, 1'b0, 1'b1, 32'h3000, 32'h0);
        op(2'd3, 1'b0, 1'b0, 32'hDEAD, 32'h0);

        // Overflow: five calls into a four-entry stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            jump_to(32'h10 * i);
            op(2'd2, 1'b0, 1'b1, 32'h800, 32'h0);
        end
        repeat (5) op(2'd3, 1'b0, 1'b1, 32'hBEEF00, 32'h0);

        // Exception under stall, eret, exception with eret
        jump_to(32'h500);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h9000, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset wins over exception with a populated stack
        op(2'd2, 1'b0, 1'b1, 32'h600, 32'h0);
        op(2'd1, 1'b1, 1'b1, 32'h0, 32'h700);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            b = $urandom;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), a, b);
        end

        @(negedge clk);
        rst = 1'b0; exception = 1'b0; eret = 1'b0; stall = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_ras.md
# pc_ras

Parametrised program-counter unit for the MIPS fetch stage; successor to the fixed-width `pc` block. It keeps the sequential, branch and absolute-jump behaviour of `pc`, selected by `pc_inc_type`. It adds four things: fetch stall, exception redirect with EPC capture, exception return, and a circular return-address stack (RAS) that predicts `jr $ra` targets. It sits between the decode/ALU branch logic and the instruction memory address port.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of every address and PC.
- `RESET_VECTOR`, 32'h0000_0000: `current_pc` value after reset.
- `EXC_VECTOR`, 32'h0000_0180: exception handler entry address.
- `RAS_DEPTH`, 4: number of RAS entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold PC and RAS this cycle.
- `pc_inc_type`  in  2: 00 sequential, 01 conditional branch, 10 absolute jump, 11 return.
- `alu_branch_result`  in  1: branch condition; used only when `pc_inc_type`=01.
- `link`  in  1: the current instruction is a call; push the return address.
- `abs_addr`  in  ADDR_WIDTH: jump target, also the fallback target for a return.
- `branch_addr`  in  ADDR_WIDTH: branch target.
- `exception`  in  1: take an exception this cycle.
- `eret`  in  1: return from exception.
- `current_pc`  out  ADDR_WIDTH: registered PC.
- `epc`  out  ADDR_WIDTH: registered exception PC.
- `ras_count`  out  $clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_hit`  out  1: registered. 1 when the last PC update was a return that used a RAS entry.

## Operation
- Define `seq` = `current_pc` + 4, computed modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC + 4 wraps to 0.
- Per-edge priority, highest first: `rst` > `exception` > `eret` > `stall` > `pc_inc_type`.
- `rst`: `current_pc`=RESET_VECTOR, `epc`=0, RAS emptied (`ras_count`=0, pointer=0), `ras_hit`=0.
- `exception`: `epc`←`current_pc`, `current_pc`←EXC_VECTOR. RAS unchanged. `ras_hit`=0.
- `eret`, with no exception: `current_pc`←`epc`. `epc` and RAS unchanged. `ras_hit`=0.
- `stall`, with no exception and no eret: all state holds, including `ras_hit`. `link` is ignored.
- `pc_inc_type`=00: `current_pc`←`seq`.
- `pc_inc_type`=01: `current_pc`←`branch_addr` if `alu_branch_result`=1, otherwise `seq`.
- `pc_inc_type`=10: `current_pc`←`abs_addr`.
- `pc_inc_type`=11 with `ras_count`>0: pop. `current_pc`←top entry, `ras_count` decrements, `ras_hit`=1.
- `pc_inc_type`=11 with `ras_count`=0: `current_pc`←`abs_addr`, `ras_hit`=0.
- `ras_hit` is 0 after every non-return update.
- Push condition: `link`=1, and either `pc_inc_type`=10 or (`pc_inc_type`=01 with `alu_branch_result`=1). The pushed value is `seq`.
- `link` is ignored for type 00, type 11 and untaken branches.
- Push when full (`ras_count`=RAS_DEPTH): the oldest entry is overwritten (circular pointer). `ras_count` saturates at RAS_DEPTH.
- RAS pointer wraps modulo RAS_DEPTH in both directions.
- Target addresses are used verbatim. No alignment masking.

## Timing
- All inputs are sampled at the rising edge. Outputs are registered and valid one cycle after the sampling edge. No combinational input-to-output paths.
- Redirect latency is one cycle: the target appears on `current_pc` after the same edge that sampled the request.
- Reset values: `current_pc`=RESET_VECTOR, `epc`=0, `ras_count`=0, `ras_hit`=0.
- Reset asserted mid-stall, or together with `exception`: reset wins, and `epc` is not updated.
- `exception` together with `stall`: the exception is taken; stall does not block redirect.
- `exception` together with `eret`: the exception wins.
- A push and a pop never occur on the same edge, because type 11 never pushes.

## Test plan
- Reset then 3 unstalled edges with type 00 (RESET_VECTOR=0) -> `current_pc` = 0, 4, 8, 12. Then `stall`=1 for 2 edges -> `current_pc` stays 12.
- From `current_pc`=0x100: type 01 with result=0 -> 0x104. Then type 01 with result=1, `branch_addr`=0x400 -> 0x400. Then type 10, `abs_addr`=0x2000 -> 0x2000. From `current_pc`=32'hFFFF_FFFC, type 00 -> 0.
- Call/return at RAS_DEPTH=4: from 0x1000, type 10 with `link`=1 and `abs_addr`=0x3000 -> `current_pc`=0x3000, `ras_count`=1. Then type 11 with `abs_addr`=0xDEAD -> `current_pc`=0x1004, `ras_hit`=1, `ras_count`=0.
- Overflow: 5 linked jumps from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> `ras_count`=4. Then 5 returns -> targets 0x54, 0x44, 0x34, 0x24, then `abs_addr` on the 5th with `ras_hit`=0.
- Exception at `current_pc`=0x500 with `stall`=1 -> `current_pc`=0x180, `epc`=0x500. Then `eret` -> 0x500. Then `exception` and `eret` together -> 0x180.
- `rst` asserted with `exception`=1 and a RAS of 2 entries -> `current_pc`=0, `epc`=0, `ras_count`=0, `ras_hit`=0.
